// File: rtl/peripheral_packet_slave.sv
// Avalon-MM pipelined slave that drains a local Avalon-ST packet buffer; read data returns READ_LATENCY cycles after acceptance.
// Backpressure: waitrequest only stalls DATA reads on an empty buffer; st_ready drops when full, in reset, or during a FLUSH write.
module peripheral_packet_slave #(
  parameter int DEPTH        = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  av_nativeaddress,
  input  logic [3:0]  av_byteenable,
  input  logic        av_read,
  input  logic        av_write,
  input  logic [31:0] av_writedata,
  output logic        av_waitrequest,
  output logic [31:0] av_readdata,
  output logic        av_readdatavalid,
  output logic        av_endofpacket,
  input  logic [31:0] st_data,
  input  logic        st_valid,
  input  logic        st_endofpacket,
  output logic        st_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level, level_nxt;
  logic [7:0]    pkt_cnt, pkt_nxt;
  logic [31:0]   scratch [16];

  logic          empty, full, wr_acc, rd_acc, flush, push, pop;
  logic [32:0]   head;
  logic [31:0]   rsp_dat;
  logic          rsp_eop;

  logic          pipe_vld [READ_LATENCY];
  logic [31:0]   pipe_dat [READ_LATENCY];
  logic          pipe_eop [READ_LATENCY];

  assign empty          = (level == '0);
  assign full           = (level == (AW+1)'(DEPTH));
  assign av_waitrequest = av_read & (av_nativeaddress == 4'd0) & empty;
  assign wr_acc         = av_write & ~av_waitrequest;
  assign rd_acc         = av_read & ~av_write & ~av_waitrequest;
  assign flush          = wr_acc & (av_nativeaddress == 4'd2) & av_byteenable[0] & av_writedata[0];
  assign st_ready       = ~full & ~reset & ~flush;
  assign push           = st_valid & st_ready;
  assign pop            = rd_acc & (av_nativeaddress == 4'd0);
  assign head           = mem[rd_ptr];
  assign level_nxt      = level + (AW+1)'(push) - (AW+1)'(pop);

  // Packet count tracks eop words in the buffer; an empty buffer always reports zero.
  always_comb begin
    pkt_nxt = pkt_cnt;
    if (push & st_endofpacket & ~(pop & head[32])) begin
      if (pkt_cnt != 8'hff) pkt_nxt = pkt_cnt + 8'd1;
    end else if (~(push & st_endofpacket) & pop & head[32]) begin
      if (pkt_cnt != 8'h00) pkt_nxt = pkt_cnt - 8'd1;
    end
    if (level_nxt == '0) pkt_nxt = 8'h00;
  end

  always_comb begin
    rsp_dat = '0;
    rsp_eop = 1'b0;
    case (av_nativeaddress)
      4'd0: begin
        rsp_dat = head[31:0];
        rsp_eop = head[32];
      end
      4'd1:    rsp_dat = {8'h00, pkt_cnt, 7'h00, 9'(level)};
      4'd2:    rsp_dat = '0;
      default: rsp_dat = scratch[av_nativeaddress];
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {st_endofpacket, st_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      pkt_cnt <= '0;
      for (int i = 0; i < 16; i++) scratch[i] <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_dat[i] <= '0;
        pipe_eop[i] <= 1'b0;
      end
    end else begin
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level   <= '0;
        pkt_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        level   <= level_nxt;
        pkt_cnt <= pkt_nxt;
      end
      if (wr_acc && av_nativeaddress >= 4'd3) begin
        for (int b = 0; b < 4; b++)
          if (av_byteenable[b]) scratch[av_nativeaddress][8*b +: 8] <= av_writedata[8*b +: 8];
      end
      // Response shift register: fields are captured at acceptance, so later writes never leak in.
      pipe_vld[0] <= rd_acc;
      pipe_dat[0] <= rsp_dat;
      pipe_eop[0] <= rsp_eop & rd_acc;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
        pipe_eop[i] <= pipe_eop[i-1];
      end
    end
  end

  assign av_readdatavalid = pipe_vld[READ_LATENCY-1];
  assign av_readdata      = pipe_dat[READ_LATENCY-1];
  assign av_endofpacket   = pipe_eop[READ_LATENCY-1] & pipe_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_peripheral_packet_slave.sv
// Randomised scoreboard bench for peripheral_packet_slave against a queue-based reference model.
module tb_peripheral_packet_slave;
  localparam int DEPTH = 32;
  localparam int RL    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  av_nativeaddress, av_byteenable;
  logic        av_read, av_write;
  logic [31:0] av_writedata, av_readdata, st_data;
  logic        av_waitrequest, av_readdatavalid, av_endofpacket;
  logic        st_valid, st_endofpacket, st_ready;

  always #5 clk = ~clk;

  peripheral_packet_slave #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .av_nativeaddress(av_nativeaddress), .av_byteenable(av_byteenable),
    .av_read(av_read), .av_write(av_write), .av_writedata(av_writedata),
    .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
    .av_readdatavalid(av_readdatavalid), .av_endofpacket(av_endofpacket),
    .st_data(st_data), .st_valid(st_valid), .st_endofpacket(st_endofpacket),
    .st_ready(st_ready)
  );

  typedef struct {
    logic [31:0] dat;
    logic        eop;
    int          due;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [32:0] bq[$];
  logic [31:0] sc[16];
  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", nm, act, exp, cyc_cnt);
    end
  endtask

  function automatic logic [31:0] model_status();
    int n = 0;
    foreach (bq[i]) if (bq[i][32]) n++;
    if (n > 255) n = 255;
    return {8'h00, 8'(n), 7'h00, 9'(bq.size())};
  endfunction

  // Monitor: every response must match the oldest expectation, on the exact cycle it is due.
  always @(negedge clk) begin
    rsp_t e;
    if (av_readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_readdatavalid", 32'(av_readdatavalid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("readdata", av_readdata, e.dat);
        chk("endofpacket", 32'(av_endofpacket), 32'(e.eop));
        chk("rsp_cycle", 32'(cyc_cnt), 32'(e.due));
      end
    end else if (av_endofpacket === 1'b1) begin
      chk("eop_without_valid", 32'(av_endofpacket), 32'd0);
    end
  end

  task automatic cyc(input logic rd, input logic wr, input logic [3:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input logic sv, input logic [31:0] sd, input logic se);
    logic        exp_wait, acc, flsh, exp_rdy;
    rsp_t        r;
    av_read = rd; av_write = wr; av_nativeaddress = addr; av_byteenable = be; av_writedata = wd;
    st_valid = sv; st_data = sd; st_endofpacket = se;
    #1;
    exp_wait = rd && addr == 4'd0 && bq.size() == 0;
    chk("waitrequest", 32'(av_waitrequest), 32'(exp_wait));
    acc     = (rd || wr) && !exp_wait;
    flsh    = acc && wr && addr == 4'd2 && be[0] && wd[0];
    exp_rdy = bq.size() < DEPTH && !flsh;
    chk("st_ready", 32'(st_ready), 32'(exp_rdy));
    if (acc && rd && !wr) begin
      r.eop = 1'b0;
      r.due = cyc_cnt + RL;
      case (addr)
        4'd0: begin
          r.dat = bq[0][31:0];
          r.eop = bq[0][32];
          void'(bq.pop_front());
        end
        4'd1:    r.dat = model_status();
        4'd2:    r.dat = 32'd0;
        default: r.dat = sc[addr];
      endcase
      exp_q.push_back(r);
    end
    if (acc && wr && addr >= 4'd3)
      for (int b = 0; b < 4; b++) if (be[b]) sc[addr][8*b +: 8] = wd[8*b +: 8];
    if (flsh) bq.delete();
    if (sv && exp_rdy) bq.push_back({se, sd});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 4'd0, 4'h0, 32'd0, 0, 32'd0, 0);
  endtask

  task automatic do_reset(input int n);
    av_read = 0; av_write = 0; av_nativeaddress = '0; av_byteenable = '0; av_writedata = '0;
    st_valid = 0; st_data = '0; st_endofpacket = 0;
    reset = 1'b1;
    // Only a response already on the bus this cycle survives the reset edge.
    for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].due > cyc_cnt) exp_q.delete(i);
    bq.delete();
    for (int i = 0; i < 16; i++) sc[i] = '0;
    #1;
    chk("reset_st_ready", 32'(st_ready), 32'd0);
    repeat (n) @(posedge clk);
    #1;
    chk("reset_rdv", 32'(av_readdatavalid), 32'd0);
    chk("reset_readdata", av_readdata, 32'd0);
    chk("reset_eop", 32'(av_endofpacket), 32'd0);
    chk("reset_waitreq", 32'(av_waitrequest), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] a;
    int         op;
    do_reset(2);

    // STATUS after reset
    cyc(1, 0, 4'd1, 4'hF, 32'd0, 0, 32'd0, 0);
    idle(3);

    // Three-word packet, back-to-back DATA reads
    cyc(0, 0, 4'd0, 4'h0, 32'd0, 1, 32'hA1, 0);
    cyc(0, 0, 4'd0, 4'h0, 32'd0, 1, 32'hA2, 0);
    cyc(0, 0, 4'd0, 4'h0, 32'd0, 1, 32'hA3, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 4'd0, 4'hF, 32'd0, 0, 32'd0, 0);
    cyc(1, 0, 4'd1, 4'hF, 32'd0, 0, 32'd0, 0);
    idle(3);

    // DATA read stalled on empty buffer until a word lands
    cyc(1, 0, 4'd0, 4'hF, 32'd0, 0, 32'd0, 0);
    cyc(1, 0, 4'd0, 4'hF, 32'd0, 0, 32'd0, 0);
    cyc(1, 0, 4'd0, 4'hF, 32'd0, 1, 32'h12345678, 1);
    cyc(1, 0, 4'd0, 4'hF, 32'd0, 0, 32'd0, 0);
    idle(4);

    // Fill to DEPTH with valid held, then push+pop interplay
    for (int i = 0; i <= DEPTH; i++) cyc(0, 0, 4'd0, 4'h0, 32'd0, 1, 32'h100 + 32'(i), 1'($urandom_range(0, 1)));
    cyc(1, 0, 4'd1, 4'hF, 32'd0, 1, 32'h999, 0);
    cyc(1, 0, 4'd0, 4'hF, 32'd0, 1, 32'h999, 1);
    cyc(1, 0, 4'd0, 4'hF, 32'd0, 1, 32'h99A, 1);
    cyc(1, 0, 4'd1, 4'hF, 32'd0, 1, 32'h99B, 0);
    cyc(1, 0, 4'd1, 4'hF, 32'd0, 0, 32'd0, 0);
    idle(3);

    // SCRATCH byte lanes and read+write collision
    cyc(0, 1, 4'd5, 4'hF, 32'hFFFFFFFF, 0, 32'd0, 0);
    cyc(0, 1, 4'd5, 4'h1, 32'h000000AA, 0, 32'd0, 0);
    cyc(1, 0, 4'd5, 4'hF, 32'd0, 0, 32'd0, 0);
    cyc(1, 1, 4'd5, 4'hF, 32'h00000011, 0, 32'd0, 0);
    cyc(1, 0, 4'd5, 4'hF, 32'd0, 0, 32'd0, 0);
    cyc(1, 0, 4'd2, 4'hF, 32'd0, 0, 32'd0, 0);
    idle(3);

    // FLUSH with push in the same cycle
    cyc(0, 1, 4'd2, 4'hF, 32'd1, 0, 32'd0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 4'd0, 4'h0, 32'd0, 1, 32'h200 + 32'(i), i == 4 || i == 9);
    cyc(1, 0, 4'd1, 4'hF, 32'd0, 0, 32'd0, 0);
    cyc(0, 1, 4'd2, 4'hF, 32'd1, 1, 32'h777, 1);
    cyc(1, 0, 4'd1, 4'hF, 32'd0, 0, 32'd0, 0);
    idle(3);

    // Reset with reads in flight
    cyc(0, 0, 4'd0, 4'h0, 32'd0, 1, 32'h333, 1);
    cyc(1, 0, 4'd1, 4'hF, 32'd0, 0, 32'd0, 0);
    cyc(1, 0, 4'd0, 4'hF, 32'd0, 0, 32'd0, 0);
    do_reset(2);
    idle(5);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 9);
      a  = 4'($urandom_range(0, 15));
      case (op)
        0, 1, 2: cyc(1, 0, 4'd0, 4'hF, 32'd0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0));
        3:       cyc(1, 0, 4'd1, 4'hF, 32'd0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0));
        4, 5:    cyc(1, 0, a, 4'hF, 32'd0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0));
        6:       cyc(0, 1, a, 4'($urandom_range(0, 15)), {$urandom_range(0, 65535), 15'd0, 1'($urandom_range(0, 15) == 0)},
                     1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0));
        7:       cyc(1, 1, a, 4'hF, $urandom & 32'hFFFF_FFFE, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0));
        default: cyc(0, 0, 4'd0, 4'h0, 32'd0, 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) == 0));
      endcase
    end

    idle(RL + 3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
